gpio_port_demux: RTL and testbench

Registered, parametrised GPIO output demultiplexer that routes the CPU's GPIO output byte to one of `NPORTS` output ports, each `WIDTH` bits wide. Unlike a purely combinational steer, every port holds its last value in a register, and writes are strobe-qualified. Each write can perform write, set, clear or toggle on the selected port. It sits between the uC GPIO output register and the chip-level port pins, and gives the core a readback path for read-modify-write sequences.

---
 rtl/gpio_port_demux.sv | 90 +++++++++
 tb/tb_gpio_port_demux.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_demux.sv
// Registered GPIO output demultiplexer. It steers the core's GPIO byte into one of NPORTS
// held port registers, using write/set/clear/toggle ops and a readback path.
module gpio_port_demux #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NPORTS = 4,
    parameter int unsigned SELW   = 2,
    parameter bit          HOLD   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [1:0]               op,
    input  logic [SELW-1:0]          sel,
    input  logic [WIDTH-1:0]         gpio_out,
    output logic [NPORTS*WIDTH-1:0]  port_out,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     err
);

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic [WIDTH-1:0] port_q [NPORTS];
    logic [WIDTH-1:0] port_d [NPORTS];
    logic             sel_valid;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       o,
                                                  input logic [WIDTH-1:0] cur,
                                                  input logic [WIDTH-1:0] mask);
        logic [WIDTH-1:0] res;
        res = cur;
        case (o)
            OP_WRITE:  res = mask;
            OP_SET:    res = cur | mask;
            OP_CLEAR:  res = cur & ~mask;
            OP_TOGGLE: res = cur ^ mask;
            default:   res = cur;
        endcase
        return res;
    endfunction

    always_comb begin
        sel_valid = (32'(sel) < NPORTS);
    end

    // Next port values: selected port takes the op, others hold or clear in exclusive mode
    always_comb begin
        for (int unsigned k = 0; k < NPORTS; k++) begin
            port_d[k] = port_q[k];
            if (wr_en && sel_valid) begin
                if (SELW'(k) == sel) begin
                    port_d[k] = apply_op(op, port_q[k], gpio_out);
                end else if (HOLD == 1'b0) begin
                    port_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                port_q[k] <= '0;
            end
            err <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NPORTS; k++) begin
                port_q[k] <= port_d[k];
            end
            err <= wr_en && !sel_valid;
        end
    end

    // Readback is unqualified by wr_en; an out-of-range sel reads zero
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (SELW'(k) == sel) begin
                rd_data = port_q[k];
            end
        end
    end

    for (genvar g = 0; g < int'(NPORTS); g++) begin : g_port
        assign port_out[g*WIDTH +: WIDTH] = port_q[g];
    end

endmodule

// File: tb/tb_gpio_port_demux.sv
// Bench for gpio_port_demux. Three configurations share one directed stimulus stream
// and are checked every cycle against an array-based model of the port registers.
module tb_gpio_port_demux;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [7:0]  gpio_out;

    logic [31:0] po_a, po_b;
    logic [23:0] po_c;
    logic [7:0]  rd_a, rd_b, rd_c;
    logic        err_a, err_b, err_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Configuration A: default (HOLD=1, 4 ports)
    gpio_port_demux #(.WIDTH(8), .NPORTS(4), .SELW(2), .HOLD(1'b1)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .op(op), .sel(sel), .gpio_out(gpio_out),
        .port_out(po_a), .rd_data(rd_a), .err(err_a));
    // Configuration B: legacy exclusive mode (HOLD=0)
    gpio_port_demux #(.WIDTH(8), .NPORTS(4), .SELW(2), .HOLD(1'b0)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .op(op), .sel(sel), .gpio_out(gpio_out),
        .port_out(po_b), .rd_data(rd_b), .err(err_b));
    // Configuration C: 3 ports, so sel=3 is out of range
    gpio_port_demux #(.WIDTH(8), .NPORTS(3), .SELW(2), .HOLD(1'b1)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .op(op), .sel(sel), .gpio_out(gpio_out),
        .port_out(po_c), .rd_data(rd_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: m[config][port]
    logic [7:0] m [3][4];
    logic       m_err [3];
    int         np   [3] = '{4, 4, 3};
    bit         hold [3] = '{1'b1, 1'b0, 1'b1};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) m[i][k] = 8'h00;
                m_err[i] = 1'b0;
            end else if (wr_en && int'(sel) < np[i]) begin
                logic [7:0] cur, nxt;
                cur = m[i][sel];
                case (op)
                    2'd0: nxt = gpio_out;
                    2'd1: nxt = cur | gpio_out;
                    2'd2: nxt = cur & ~gpio_out;
                    default: nxt = cur ^ gpio_out;
                endcase
                for (int k = 0; k < np[i]; k++) begin
                    if (k == int'(sel)) m[i][k] = nxt;
                    else if (!hold[i]) m[i][k] = 8'h00;
                end
                m_err[i] = 1'b0;
            end else begin
                m_err[i] = wr_en;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_po(input int i);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < np[i]; k++) v[k*8 +: 8] = m[i][k];
        return v;
    endfunction

    function automatic logic [7:0] exp_rd(input int i);
        return (int'(sel) < np[i]) ? m[i][sel] : 8'h00;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("a.port_out", po_a, exp_po(0));
        check("b.port_out", po_b, exp_po(1));
        check("c.port_out", {8'h00, po_c}, exp_po(2));
        check("a.rd_data", 32'(rd_a), 32'(exp_rd(0)));
        check("b.rd_data", 32'(rd_b), 32'(exp_rd(1)));
        check("c.rd_data", 32'(rd_c), 32'(exp_rd(2)));
        check("a.err", 32'(err_a), 32'(m_err[0]));
        check("b.err", 32'(err_b), 32'(m_err[1]));
        check("c.err", 32'(err_c), 32'(m_err[2]));
    end

    // Apply one vector, taking effect at the next rising edge
    task automatic drive(input logic we, input logic [1:0] o, input logic [1:0] s,
                         input logic [7:0] d);
        @(posedge clk);
        #1;
        wr_en = we; op = o; sel = s; gpio_out = d;
    endtask

    localparam logic [1:0] WR = 2'd0, ST = 2'd1, CL = 2'd2, TG = 2'd3;

    initial begin
        rst = 1'b1; wr_en = 1'b0; op = WR; sel = 2'd0; gpio_out = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2 check("lit.reset_port_out", po_a, 32'h0);
        check("lit.reset_err", 32'(err_a), 32'h0);

        // WRITE with hold
        drive(1'b1, WR, 2'd2, 8'hA5);
        drive(1'b0, WR, 2'd2, 8'h00);
        #2 check("lit.rd_sel2", 32'(rd_a), 32'hA5);
        drive(1'b1, WR, 2'd0, 8'h3C);
        drive(1'b0, WR, 2'd0, 8'h00);
        #2 check("lit.a_write", po_a, 32'h00A5_003C);
        check("lit.b_write_excl", po_b, 32'h0000_003C);

        // Back-to-back read-modify-write on port 1
        drive(1'b1, WR, 2'd1, 8'hF0);
        drive(1'b1, ST, 2'd1, 8'h0F);
        #2 check("lit.rmw_write", 32'(rd_a), 32'hF0);
        drive(1'b1, CL, 2'd1, 8'h81);
        #2 check("lit.rmw_set", 32'(rd_a), 32'hFF);
        drive(1'b1, TG, 2'd1, 8'hFF);
        #2 check("lit.rmw_clear", 32'(rd_a), 32'h7E);
        drive(1'b0, WR, 2'd1, 8'h00);
        #2 check("lit.rmw_toggle", 32'(rd_a), 32'h81);

        // Exclusive mode clears the unselected port
        drive(1'b1, WR, 2'd0, 8'h11);
        drive(1'b1, WR, 2'd1, 8'h22);
        drive(1'b0, WR, 2'd0, 8'h00);
        #2 check("lit.b_excl", po_b, 32'h0000_2200);

        // Out-of-range select on the 3-port instance
        drive(1'b1, WR, 2'd3, 8'hFF);
        drive(1'b0, WR, 2'd3, 8'h00);
        #2 check("lit.c_err", 32'(err_c), 32'h1);
        check("lit.c_rd_invalid", 32'(rd_c), 32'h0);
        check("lit.c_unchanged", 32'(po_c), 32'h00A5_2211);
        drive(1'b0, WR, 2'd3, 8'h00);
        #2 check("lit.c_err_oneshot", 32'(err_c), 32'h0);

        // Consecutive invalid writes keep err high
        drive(1'b1, ST, 2'd3, 8'h01);
        drive(1'b1, TG, 2'd3, 8'h02);
        drive(1'b0, WR, 2'd0, 8'h00);
        #2 check("lit.c_err_held", 32'(err_c), 32'h1);

        // Async reset with ports loaded, checked before any clock edge
        drive(1'b0, WR, 2'd2, 8'h00);
        #1 rst = 1'b1;
        #1 check("lit.async_rst_a", po_a, 32'h0);
        check("lit.async_rst_c", 32'(po_c), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed mixed traffic over every op and select
        drive(1'b1, WR, 2'd3, 8'h5A);
        drive(1'b1, ST, 2'd2, 8'hC3);
        drive(1'b1, TG, 2'd3, 8'h0F);
        drive(1'b0, CL, 2'd3, 8'hFF);
        drive(1'b1, CL, 2'd2, 8'h41);
        drive(1'b1, TG, 2'd0, 8'hAA);
        drive(1'b1, ST, 2'd0, 8'h05);
        drive(1'b1, WR, 2'd1, 8'h99);
        drive(1'b1, CL, 2'd3, 8'hF0);
        drive(1'b0, WR, 2'd0, 8'h00);
        #2 check("lit.mix_a", po_a, 32'h0582_99AF);

        // Reset asserted during a toggle write discards it
        drive(1'b1, TG, 2'd0, 8'hFF);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; wr_en = 1'b0;
        #2 check("lit.rst_mid_a", po_a, 32'h0);
        check("lit.rst_mid_b", po_b, 32'h0);
        drive(1'b0, WR, 2'd0, 8'h00);
        drive(1'b0, WR, 2'd0, 8'h00);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
